// File: rtl/dcom_pkg.sv
// dcom_pkg -- shared definitions for the UART transmit FIFO (dcom_txfifo).
// Holds the APB register map, STAT/CTRL bit positions, the drain FSM state
// encoding and a helper that assembles the STAT read word.
package dcom_pkg;

   // Register offsets, decoded on PADDR[5:0]
   localparam logic [5:0] ADDR_DATA = 6'h00;
   localparam logic [5:0] ADDR_STAT = 6'h04;
   localparam logic [5:0] ADDR_CTRL = 6'h08;

   // STAT bit positions
   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVF       = 2;
   localparam int STAT_COUNT_LSB = 4;
   localparam int STAT_COUNT_MSB = 12;

   // CTRL bit positions
   localparam int CTRL_EN      = 0;
   localparam int CTRL_FLUSH   = 1;
   localparam int CTRL_THR_LSB = 4;
   localparam int CTRL_THR_MSB = 7;

   // Drain FSM states
   typedef enum logic [1:0] {
      DRAIN_IDLE  = 2'd0,
      DRAIN_ISSUE = 2'd1,
      DRAIN_WAIT  = 2'd2
   } drainState_t;

   // Builds the STAT word; the count field is 9 bits wide so it covers DEPTH up to 256
   function automatic logic [31:0] packStat(input logic [8:0] count,
                                            input logic       ovf,
                                            input logic       full,
                                            input logic       empty);
      logic [31:0] word;
      word = '0;
      word[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
      word[STAT_OVF]   = ovf;
      word[STAT_FULL]  = full;
      word[STAT_EMPTY] = empty;
      return word;
   endfunction

endpackage

// File: rtl/dcom_txfifo_if.sv
// dcom_txfifo_if -- APB slave bus bundle for the UART transmit FIFO.
// The master modport is the APB bridge side; the slave modport is the FIFO side.
interface dcom_txfifo_if;

   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;

   modport master (
      output PSEL,
      output PENABLE,
      output PWRITE,
      output PADDR,
      output PWDATA,
      input  PRDATA
   );

   modport slave (
      input  PSEL,
      input  PENABLE,
      input  PWRITE,
      input  PADDR,
      input  PWDATA,
      output PRDATA
   );

endinterface

// File: rtl/dcom_fifo_core.sv
// dcom_fifo_core -- byte-wide circular FIFO storage with read/write pointers
// and an occupancy count. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; flush empties the FIFO and discards any push or
// pop presented alongside it. Storage is never reset, only the pointers are.
module dcom_fifo_core #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic [7:0]    i_pushData,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [7:0]    o_headData,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_pushAccepted
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_count;
   logic          w_pushOk;
   logic          w_popOk;

   assign o_full         = (r_count == FULL_COUNT);
   assign o_empty        = (r_count == '0);
   assign w_popOk        = i_pop & ~o_empty & ~i_flush;
   assign w_pushOk       = i_push & ~i_flush & (~o_full | w_popOk);
   assign o_pushAccepted = w_pushOk;
   assign o_headData     = r_mem[r_rdPtr];
   assign o_count        = r_count;

   // Write accepted bytes into storage; contents deliberately survive reset
   always_ff @(posedge i_clk) begin
      if (w_pushOk) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   // Advance pointers (wrapping at DEPTH) and track occupancy; flush clears all
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_pushOk) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_popOk) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         r_count <= r_count + {{AW{1'b0}}, w_pushOk} - {{AW{1'b0}}, w_popOk};
      end
   end

endmodule

// File: rtl/dcom_txfifo.sv
// dcom_txfifo -- APB-programmed transmit FIFO that feeds a UART one byte at a
// time. Registers: DATA (push), STAT (count/overflow/full/empty), CTRL
// (enable, self-clearing flush, IRQ threshold). A three-state drain FSM pops
// a byte when the UART hold register is empty and strobes TxWrite for one
// cycle, then waits one cycle because THEmpty is stale right after a write.
// Optional feature macro: DCOM_TXFIFO_IRQ_EN adds the TxIrq low-level
// interrupt output and the CTRL threshold field.
module dcom_txfifo
   import dcom_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               PCLK,
   input  logic               PRST,
   dcom_txfifo_if.slave       apb,
   input  logic               THEmpty,
   output logic               TxWrite,
   output logic [7:0]         TxData
`ifdef DCOM_TXFIFO_IRQ_EN
   ,
   output logic               TxIrq
`endif
);

   logic [5:0]  w_addr;
   logic        w_apbWrite;
   logic        w_apbRead;
   logic        w_wrData;
   logic        w_wrStat;
   logic        w_wrCtrl;
   logic        w_flush;
   logic        w_pop;
   logic [7:0]  w_headData;
   logic [AW:0] w_count;
   logic        w_full;
   logic        w_empty;
   logic        w_pushAccepted;
   logic [31:0] w_statWord;
   logic [31:0] w_ctrlWord;
   logic        w_unusedBits;

   logic        r_en;
   logic        r_ovf;
   logic [7:0]  r_txData;
   drainState_t r_state;
   drainState_t w_nextState;

`ifdef DCOM_TXFIFO_IRQ_EN
   logic [3:0]  r_thr;
   logic        r_txIrq;
`endif

   assign w_addr     = apb.PADDR[5:0];
   assign w_apbWrite = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign w_apbRead  = apb.PSEL & ~apb.PWRITE;
   assign w_wrData   = w_apbWrite & (w_addr == ADDR_DATA);
   assign w_wrStat   = w_apbWrite & (w_addr == ADDR_STAT);
   assign w_wrCtrl   = w_apbWrite & (w_addr == ADDR_CTRL);
   assign w_flush    = w_wrCtrl & apb.PWDATA[CTRL_FLUSH];

   assign w_unusedBits = ^{apb.PADDR[31:6], apb.PWDATA[31:8]};

   dcom_fifo_core #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_core (
      .i_clk          (PCLK),
      .i_rst          (PRST),
      .i_push         (w_wrData),
      .i_pushData     (apb.PWDATA[7:0]),
      .i_pop          (w_pop),
      .i_flush        (w_flush),
      .o_headData     (w_headData),
      .o_count        (w_count),
      .o_full         (w_full),
      .o_empty        (w_empty),
      .o_pushAccepted (w_pushAccepted)
   );

   // CTRL storage: enable bit and (optionally) the IRQ threshold; flush is not stored
   always_ff @(posedge PCLK) begin
      if (PRST) begin
         r_en <= 1'b0;
`ifdef DCOM_TXFIFO_IRQ_EN
         r_thr <= 4'h0;
`endif
      end else if (w_wrCtrl) begin
         r_en <= apb.PWDATA[CTRL_EN];
`ifdef DCOM_TXFIFO_IRQ_EN
         r_thr <= apb.PWDATA[CTRL_THR_MSB:CTRL_THR_LSB];
`endif
      end
   end

   // Sticky overflow: set by a dropped push, cleared by writing 1 to STAT bit 2
   always_ff @(posedge PCLK) begin
      if (PRST) begin
         r_ovf <= 1'b0;
      end else if (w_wrStat && apb.PWDATA[STAT_OVF]) begin
         r_ovf <= 1'b0;
      end else if (w_wrData && !w_pushAccepted) begin
         r_ovf <= 1'b1;
      end
   end

   // Assemble the readable CTRL word; flush always reads back as zero
   always_comb begin
      w_ctrlWord = '0;
      w_ctrlWord[CTRL_EN] = r_en;
`ifdef DCOM_TXFIFO_IRQ_EN
      w_ctrlWord[CTRL_THR_MSB:CTRL_THR_LSB] = r_thr;
`endif
   end

   assign w_statWord = packStat(9'(w_count), r_ovf, w_full, w_empty);

   // APB read mux: only drives data during a read to a mapped readable register
   always_comb begin
      apb.PRDATA = '0;
      if (w_apbRead) begin
         case (w_addr)
            ADDR_STAT: apb.PRDATA = w_statWord;
            ADDR_CTRL: apb.PRDATA = w_ctrlWord;
            default:   apb.PRDATA = '0;
         endcase
      end
   end

   // Drain FSM state register
   always_ff @(posedge PCLK) begin
      if (PRST) begin
         r_state <= DRAIN_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Drain FSM next state and pop decision; ISSUE and WAIT always run to completion
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      case (r_state)
         DRAIN_IDLE: begin
            if (r_en && !w_empty && THEmpty && !w_flush) begin
               w_pop       = 1'b1;
               w_nextState = DRAIN_ISSUE;
            end
         end
         DRAIN_ISSUE: begin
            w_nextState = DRAIN_WAIT;
         end
         DRAIN_WAIT: begin
            w_nextState = DRAIN_IDLE;
         end
         default: begin
            w_nextState = DRAIN_IDLE;
         end
      endcase
   end

   // Capture the popped head byte; it stays on TxData until the next pop
   always_ff @(posedge PCLK) begin
      if (PRST) begin
         r_txData <= 8'h00;
      end else if (w_pop) begin
         r_txData <= w_headData;
      end
   end

   assign TxWrite = (r_state == DRAIN_ISSUE);
   assign TxData  = r_txData;

`ifdef DCOM_TXFIFO_IRQ_EN
   // Registered low-level interrupt: enabled and occupancy at or below threshold
   always_ff @(posedge PCLK) begin
      if (PRST) begin
         r_txIrq <= 1'b0;
      end else begin
         r_txIrq <= r_en & (9'(w_count) <= 9'(r_thr));
      end
   end

   assign TxIrq = r_txIrq;
`endif

endmodule

// File: tb/tb_dcom_txfifo.sv
// tb_dcom_txfifo -- directed self-checking bench for dcom_txfifo.
// Bytes expected on the UART side are queued when written and compared as
// TxWrite strobes appear. Define DCOM_TXFIFO_IRQ_EN to include the TxIrq step.
module tb_dcom_txfifo;
   import dcom_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic       PCLK = 1'b0;
   logic       PRST;
   logic       THEmpty;
   logic       TxWrite;
   logic [7:0] TxData;
`ifdef DCOM_TXFIFO_IRQ_EN
   logic       TxIrq;
`endif

   dcom_txfifo_if apbIf();

   int         checks    = 0;
   int         failures  = 0;
   int         cycle     = 0;
   int         txCount   = 0;
   int         lastPulse = -1;
   int         pulseCyc[$];
   logic [7:0] sbQ[$];

   dcom_txfifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .PCLK    (PCLK),
      .PRST    (PRST),
      .apb     (apbIf),
      .THEmpty (THEmpty),
      .TxWrite (TxWrite),
      .TxData  (TxData)
`ifdef DCOM_TXFIFO_IRQ_EN
      ,
      .TxIrq   (TxIrq)
`endif
   );

   // Free-running clock
   always #5 PCLK = ~PCLK;

   // Cycle counter used to measure strobe spacing
   always @(posedge PCLK) cycle++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // UART-side monitor: every strobe must carry the oldest queued byte
   always @(negedge PCLK) begin
      if (TxWrite === 1'b1) begin
         txCount++;
         pulseCyc.push_back(cycle);
         if (lastPulse >= 0) begin
            checkOutput("txSpacing", 32'((cycle - lastPulse) >= 3), 32'd1);
         end
         lastPulse = cycle;
         checkOutput("txExpected", 32'(sbQ.size() != 0), 32'd1);
         if (sbQ.size() != 0) begin
            checkOutput("txData", 32'(TxData), 32'(sbQ.pop_front()));
         end
      end
   end

   // Safety net so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data);
      @(negedge PCLK);
      apbIf.PSEL    = 1'b1;
      apbIf.PENABLE = 1'b0;
      apbIf.PWRITE  = 1'b1;
      apbIf.PADDR   = {26'h0, addr};
      apbIf.PWDATA  = data;
      @(negedge PCLK);
      apbIf.PENABLE = 1'b1;
      @(negedge PCLK);
      apbIf.PSEL    = 1'b0;
      apbIf.PENABLE = 1'b0;
      apbIf.PWRITE  = 1'b0;
   endtask

   task automatic readNow(input logic [5:0] addr, output logic [31:0] data);
      apbIf.PSEL    = 1'b1;
      apbIf.PENABLE = 1'b0;
      apbIf.PWRITE  = 1'b0;
      apbIf.PADDR   = {26'h0, addr};
      #1;
      data = apbIf.PRDATA;
      apbIf.PSEL    = 1'b0;
   endtask

   task automatic readReg(input logic [5:0] addr, output logic [31:0] data);
      @(negedge PCLK);
      readNow(addr, data);
   endtask

   task automatic pushByte(input logic [7:0] b, input bit expectTx);
      applyStimulus(ADDR_DATA, {24'h0, b});
      if (expectTx) sbQ.push_back(b);
   endtask

   task automatic waitDrain(input int maxCycles);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < maxCycles) begin
         @(negedge PCLK);
         n++;
      end
      checkOutput("drainDone", 32'(sbQ.size()), 32'd0);
      repeat (4) @(negedge PCLK);
   endtask

   initial begin
      logic [31:0] rd;
      int          base;
      int          seenAt;

      PRST          = 1'b1;
      THEmpty       = 1'b0;
      apbIf.PSEL    = 1'b0;
      apbIf.PENABLE = 1'b0;
      apbIf.PWRITE  = 1'b0;
      apbIf.PADDR   = '0;
      apbIf.PWDATA  = '0;
      repeat (3) @(negedge PCLK);

      // Reset state
      checkOutput("rstTxWrite", 32'(TxWrite), 32'd0);
      checkOutput("rstTxData", 32'(TxData), 32'h00);
`ifdef DCOM_TXFIFO_IRQ_EN
      checkOutput("rstTxIrq", 32'(TxIrq), 32'd0);
`endif
      PRST = 1'b0;
      readReg(ADDR_STAT, rd);
      checkOutput("rstStat", rd, 32'h0000_0001);
      readReg(ADDR_CTRL, rd);
      checkOutput("rstCtrl", rd, 32'h0);

      // Drain disabled: two queued bytes, no strobes even with THEmpty high
      THEmpty = 1'b1;
      pushByte(8'hA5, 1'b1);
      pushByte(8'h3C, 1'b1);
      readReg(ADDR_STAT, rd);
      checkOutput("statTwo", rd, 32'h0000_0020);
      readReg(ADDR_DATA, rd);
      checkOutput("dataWriteOnly", rd, 32'h0);
      readReg(6'h0C, rd);
      checkOutput("unmappedRead", rd, 32'h0);
      @(negedge PCLK);
      checkOutput("prdataIdle", apbIf.PRDATA, 32'h0);
      repeat (5) @(negedge PCLK);
      checkOutput("noTxDisabled", 32'(txCount), 32'd0);

      // Enable drain with three bytes queued: back-to-back strobes 3 cycles apart
      pushByte(8'h5A, 1'b1);
      base = txCount;
      applyStimulus(ADDR_CTRL, 32'h1);
      waitDrain(40);
      checkOutput("burstPulses", 32'(txCount - base), 32'd3);
      if (pulseCyc.size() >= base + 3) begin
         checkOutput("burstGap1", 32'(pulseCyc[base+1] - pulseCyc[base]), 32'd3);
         checkOutput("burstGap2", 32'(pulseCyc[base+2] - pulseCyc[base+1]), 32'd3);
      end
      readReg(ADDR_STAT, rd);
      checkOutput("statDrained", rd, 32'h0000_0001);
      readReg(ADDR_CTRL, rd);
      checkOutput("ctrlEn", rd, 32'h1);
      applyStimulus(ADDR_CTRL, 32'h0);

      // Overfill: 17 writes with drain off, 17th dropped and Ovf raised
      for (int i = 0; i < 17; i++) begin
         pushByte(8'h10 + 8'(i), i < 16);
      end
      readReg(ADDR_STAT, rd);
      checkOutput("statOverflow", rd, 32'h0000_0106);
      applyStimulus(ADDR_STAT, 32'h4);
      readReg(ADDR_STAT, rd);
      checkOutput("statOvfClear", rd, 32'h0000_0102);

      // Full FIFO: a DATA write in the same cycle as a pop is accepted
      THEmpty = 1'b0;
      base = txCount;
      applyStimulus(ADDR_CTRL, 32'h1);
      repeat (2) @(negedge PCLK);
      checkOutput("heldByTHEmpty", 32'(txCount - base), 32'd0);
      @(negedge PCLK);
      apbIf.PSEL    = 1'b1;
      apbIf.PENABLE = 1'b0;
      apbIf.PWRITE  = 1'b1;
      apbIf.PADDR   = {26'h0, ADDR_DATA};
      apbIf.PWDATA  = 32'h77;
      @(negedge PCLK);
      apbIf.PENABLE = 1'b1;
      THEmpty       = 1'b1;
      @(negedge PCLK);
      apbIf.PSEL    = 1'b0;
      apbIf.PENABLE = 1'b0;
      apbIf.PWRITE  = 1'b0;
      THEmpty       = 1'b0;
      sbQ.push_back(8'h77);
      readReg(ADDR_STAT, rd);
      checkOutput("statFullPopPush", rd, 32'h0000_0102);
      checkOutput("fullPopPulse", 32'(txCount - base), 32'd1);
      THEmpty = 1'b1;
      waitDrain(200);
      readReg(ADDR_STAT, rd);
      checkOutput("statAfterFull", rd, 32'h0000_0001);
      checkOutput("fullDrainPulses", 32'(txCount - base), 32'd17);

      // Flush during WAIT: in-flight byte completes, remaining bytes discarded
      THEmpty = 1'b0;
      pushByte(8'h81, 1'b1);
      pushByte(8'h82, 1'b0);
      pushByte(8'h83, 1'b0);
      base = txCount;
      @(negedge PCLK);
      THEmpty = 1'b1;
      @(negedge PCLK);
      checkOutput("flushIssue", 32'(TxWrite), 32'd1);
      apbIf.PSEL    = 1'b1;
      apbIf.PENABLE = 1'b0;
      apbIf.PWRITE  = 1'b1;
      apbIf.PADDR   = {26'h0, ADDR_CTRL};
      apbIf.PWDATA  = 32'h3;
      @(negedge PCLK);
      checkOutput("flushWaitState", 32'(TxWrite), 32'd0);
      apbIf.PENABLE = 1'b1;
      @(negedge PCLK);
      apbIf.PENABLE = 1'b0;
      apbIf.PWRITE  = 1'b0;
      readNow(ADDR_STAT, rd);
      checkOutput("statFlushed", rd, 32'h0000_0001);
      readReg(ADDR_CTRL, rd);
      checkOutput("ctrlFlushReads0", rd, 32'h1);
      repeat (10) @(negedge PCLK);
      checkOutput("flushPulses", 32'(txCount - base), 32'd1);
      checkOutput("flushQueue", 32'(sbQ.size()), 32'd0);

      // Reset asserted mid-ISSUE: strobe drops on the next edge, state cleared
      THEmpty = 1'b0;
      pushByte(8'hC3, 1'b1);
      @(negedge PCLK);
      THEmpty = 1'b1;
      @(negedge PCLK);
      checkOutput("preRstIssue", 32'(TxWrite), 32'd1);
      PRST = 1'b1;
      @(negedge PCLK);
      checkOutput("rstMidTxWrite", 32'(TxWrite), 32'd0);
      checkOutput("rstMidTxData", 32'(TxData), 32'h00);
      PRST = 1'b0;
      readReg(ADDR_STAT, rd);
      checkOutput("rstMidStat", rd, 32'h0000_0001);
      readReg(ADDR_CTRL, rd);
      checkOutput("rstMidCtrl", rd, 32'h0);

`ifdef DCOM_TXFIFO_IRQ_EN
      // Threshold interrupt: rises one cycle after Count falls to 2
      THEmpty = 1'b0;
      applyStimulus(ADDR_CTRL, 32'h21);
      for (int i = 0; i < 5; i++) begin
         pushByte(8'hE0 + 8'(i), 1'b1);
      end
      readReg(ADDR_STAT, rd);
      checkOutput("irqStatFive", rd, 32'h0000_0050);
      checkOutput("irqLowAtFive", 32'(TxIrq), 32'd0);
      readReg(ADDR_CTRL, rd);
      checkOutput("ctrlThr", rd, 32'h21);
      THEmpty = 1'b1;
      seenAt = -1;
      for (int i = 0; i < 60; i++) begin
         readReg(ADDR_STAT, rd);
         if (seenAt < 0 && rd[STAT_COUNT_MSB:STAT_COUNT_LSB] == 9'd2) begin
            checkOutput("irqBeforeRise", 32'(TxIrq), 32'd0);
            seenAt = i;
         end else if (seenAt >= 0 && i == seenAt + 1) begin
            checkOutput("irqRise", 32'(TxIrq), 32'd1);
            break;
         end
      end
      checkOutput("irqCountSeen", 32'(seenAt >= 0), 32'd1);
      waitDrain(60);
      applyStimulus(ADDR_CTRL, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dcom_txfifo.md
DCOM_TXFIFO -- requirements
Module: dcom_txfifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, the FIFO entry count (power of two, 4..256).
REQ-002 SHALL have parameter AW, default 4, equal to log2(DEPTH).
REQ-003 SHALL have port PCLK  in  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port PRST  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-006 SHALL have ports PADDR, PWDATA  in  32 each  APB address and write data.
REQ-007 SHALL have port PRDATA  out  32  APB read data.
REQ-008 SHALL have port THEmpty  in  1  UART transmit-hold-empty flag.
REQ-009 SHALL have port TxWrite  out  1  one-cycle write strobe to the UART Write input.
REQ-010 SHALL have port TxData  out  8  byte to the UART DataIn input.
REQ-011 SHALL have port TxIrq  out  1  low-level interrupt; present only under the macro in REQ-032.

Function
REQ-012 SHALL decode registers on PADDR[5:0]: DATA 6'h00 (write-only), STAT 6'h04, CTRL 6'h08.
REQ-013 SHALL treat an APB write as PSEL & PENABLE & PWRITE, sampled at one edge.
REQ-014 SHALL push PWDATA[7:0] on an APB write to DATA when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-015 SHALL drop a push to a full FIFO with no concurrent pop, and set sticky STAT.Ovf.
REQ-016 SHALL return STAT as {Count[AW:0] at [12:4], Ovf [2], Full [1], Empty [0]}, with all other bits zero.
REQ-017 SHALL clear Ovf on an APB write to STAT with PWDATA[2] = 1.
REQ-018 SHALL implement CTRL[0] En (drain enable), CTRL[1] Flush (self-clearing, reads 0), and CTRL[7:4] Thr (IRQ threshold, R/W).
REQ-019 SHALL, on Flush, zero both pointers and Count in the next cycle; a push in the same cycle as Flush is discarded.
REQ-020 SHALL drive PRDATA combinationally from the addressed register when PSEL & ~PWRITE, and drive 32'h0 otherwise or for an unmapped address.
REQ-021 SHALL drain with FSM states IDLE, ISSUE, WAIT.
REQ-022 SHALL, in IDLE when En & ~Empty & THEmpty, pop the head entry into TxData and go to ISSUE.
REQ-023 SHALL assert TxWrite for exactly the ISSUE cycle, then go to WAIT unconditionally.
REQ-024 SHALL, in WAIT, ignore THEmpty (the UART flag is stale for one cycle after Write) and return to IDLE after one cycle.
REQ-025 SHALL keep consecutive TxWrite strobes at least 3 cycles apart.
REQ-026 SHALL hold TxData stable from ISSUE until the next pop.
REQ-027 SHALL let an ISSUE/WAIT already in progress complete when En is cleared or Flush is written.
REQ-028 SHALL wrap both pointers modulo DEPTH, and keep Count in the range 0..DEPTH with Full = (Count == DEPTH).

Reset
REQ-029 SHALL, while PRST is high at an edge, set FSM to IDLE, pointers and Count to 0, Ovf to 0, CTRL to 0, TxWrite to 0, and TxData to 8'h00.
REQ-030 SHALL, on reset asserted mid-ISSUE, drive TxWrite low on the following edge; the popped byte is lost.
REQ-031 SHALL not reset FIFO storage contents.

Configuration
REQ-032 SHALL, with DCOM_TXFIFO_IRQ_EN defined, drive TxIrq = En & (Count <= Thr) as a registered output, reset to 0.
REQ-033 SHALL, without DCOM_TXFIFO_IRQ_EN, omit the TxIrq port and Thr storage, with CTRL[7:4] reading 0.

Structure
REQ-034 SHALL place register offsets, STAT/CTRL bit positions and the drain FSM state encoding in shared package dcom_pkg.
REQ-035 SHALL implement storage and pointers in one sub-module, dcom_fifo_core (push, pop, flush, count, full, empty); the APB decode and FSM stay in the top.

Verification
REQ-036 SHALL cover: En=0, write 8'hA5 then 8'h3C to DATA -> STAT reads Count=2, Empty=0; TxWrite never asserts.
REQ-037 SHALL cover: En=1, THEmpty held 1, three bytes queued -> three TxWrite pulses exactly 3 cycles apart carrying A5, 3C, then the third byte in order.
REQ-038 SHALL cover: DEPTH=16, 17 writes with En=0 -> Count=16, Full=1, Ovf=1, and the 17th byte is absent when drained; writing STAT bit2=1 clears Ovf.
REQ-039 SHALL cover: with the FIFO full and a pop in progress, an APB DATA write in the pop cycle is accepted and Count stays 16.
REQ-040 SHALL cover: Flush written during WAIT -> the current byte completes, Count=0 next cycle, and no further TxWrite occurs.
REQ-041 SHALL cover: with DCOM_TXFIFO_IRQ_EN, Thr=2, En=1, draining from 5 entries -> TxIrq rises one cycle after Count reaches 2.
